// File: rtl/boot_pkg.sv
// Package shared by the boot loader, its ROM and the top-level memory-port mux.
// Holds the loader state encoding, default memory geometry and the index-width helper.
package boot_pkg;

  localparam int unsigned DEF_ADDR_W = 7;
  localparam int unsigned DEF_DATA_W = 32;

  // VRD/VCHK are only visited when readback verification is compiled in.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    VRD   = 3'd2,
    VCHK  = 3'd3,
    GUARD = 3'd4,
    RUN   = 3'd5
  } boot_state_e;

  // Width of a counter that must be able to hold the value n (one past the last word).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/boot_rom.sv
// Program image copied into MemoryB at boot (current Lab program).
// Ports:
//   idx  in   IDX_W   word index into the image
//   data out  DATA_W  image word; zero past the end of the table
// Image:
//   0 addi $1,$0,6     1 addi $2,$0,48    2 sll $8,$1,5     3 sll $9,$1,4
//   4 add $8,$8,$9     5 sw $1,80($0)     6 sw $8,84($0)    7 lw $3,80($0)
//   8 sw $3,88($0)     9 j 9 (park)
module boot_rom
  import boot_pkg::*;
#(
  parameter int unsigned IDX_W  = 4,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic [IDX_W-1:0]  idx,
  output logic [DATA_W-1:0] data
);

  // Widen the index so case items never alias for small IDX_W.
  logic [31:0] idx_ext;
  assign idx_ext = 32'(idx);

  always_comb begin
    data = '0;
    case (idx_ext)
      32'd0:   data = DATA_W'(32'h2001_0006);
      32'd1:   data = DATA_W'(32'h2002_0030);
      32'd2:   data = DATA_W'(32'h0001_4140);
      32'd3:   data = DATA_W'(32'h0001_4900);
      32'd4:   data = DATA_W'(32'h0109_4020);
      32'd5:   data = DATA_W'(32'hAC01_0050);
      32'd6:   data = DATA_W'(32'hAC08_0054);
      32'd7:   data = DATA_W'(32'h8C03_0050);
      32'd8:   data = DATA_W'(32'hAC03_0058);
      32'd9:   data = DATA_W'(32'h0800_0009);
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/boot_loader.sv
// Boot loader: owns the memory port after reset, copies the boot_rom image into
// MemoryB starting at BASE_ADDR, then holds the CPU in reset for one guard cycle
// while the top-level port mux switches back, and finally releases it.
// Ports:
//   CLK      in   1       system clock
//   rst      in   1       asynchronous active-low reset
//   start    in   1       begin load (sampled in IDLE only)
//   init     out  1       loader owns the memory port (mux select)
//   CS/WE    out  1       memory chip select / write enable
//   Address  out  ADDR_W  memory word address
//   bus_out  out  DATA_W  write data
//   bus_oe   out  1       drive bus_out onto Mem_Bus
//   bus_in   in   DATA_W  Mem_Bus read value (readback only)
//   cpu_rst  out  1       active-high CPU reset
//   done     out  1       load complete, sticky
//   err      out  1       readback mismatch, sticky
// Build option: VERIFY_READBACK_EN adds a read-and-compare pass over the loaded
// words before release; without it err stays 0 and bus_in is ignored.
module boot_loader
  import boot_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned N_WORDS    = 10,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned AUTO_START = 1
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              start,
  output logic              init,
  output logic              CS,
  output logic              WE,
  output logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe,
  input  logic [DATA_W-1:0] bus_in,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

  localparam int unsigned       IDX_W   = idx_width(N_WORDS);
  localparam logic [IDX_W-1:0]  IDX_END = IDX_W'(N_WORDS);
  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);

  boot_state_e       state;
  logic [IDX_W-1:0]  idx;       // next word to issue
  logic [DATA_W-1:0] rom_word;
  logic [ADDR_W-1:0] addr_cur;

  // Address arithmetic wraps naturally in ADDR_W bits.
  assign addr_cur = BASE + ADDR_W'(idx);

  boot_rom #(
    .IDX_W  (IDX_W),
    .DATA_W (DATA_W)
  ) u_rom (
    .idx  (idx),
    .data (rom_word)
  );

`ifdef VERIFY_READBACK_EN
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_WORDS - 1);
  logic [ADDR_W-1:0] addr_next;
  assign addr_next = BASE + ADDR_W'(idx + 1'b1);
`else
  logic unused_bus_in;
  assign unused_bus_in = ^bus_in;
`endif

  // Outputs are registered alongside the state: each transition loads the
  // values the destination state presents, so nothing glitches in between.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      idx     <= '0;
      init    <= 1'b0;
      CS      <= 1'b0;
      WE      <= 1'b0;
      bus_oe  <= 1'b0;
      Address <= '0;
      bus_out <= '0;
      cpu_rst <= 1'b1;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (AUTO_START != 0 || start) begin
            state   <= LOAD;
            init    <= 1'b1;
            CS      <= 1'b1;
            WE      <= 1'b1;
            bus_oe  <= 1'b1;
            Address <= addr_cur;
            bus_out <= rom_word;
            idx     <= idx + 1'b1;
          end
        end

        LOAD: begin
          if (idx == IDX_END) begin
`ifdef VERIFY_READBACK_EN
            state   <= VRD;
            idx     <= '0;
            WE      <= 1'b0;
            bus_oe  <= 1'b0;
            bus_out <= '0;
            Address <= BASE;
`else
            state   <= GUARD;
            init    <= 1'b0;
            CS      <= 1'b0;
            WE      <= 1'b0;
            bus_oe  <= 1'b0;
            bus_out <= '0;
            Address <= '0;
`endif
          end else begin
            Address <= addr_cur;
            bus_out <= rom_word;
            idx     <= idx + 1'b1;
          end
        end

`ifdef VERIFY_READBACK_EN
        // Address is held across VRD and VCHK so bus_in is settled at compare.
        VRD: state <= VCHK;

        VCHK: begin
          if (bus_in != rom_word) begin
            err <= 1'b1;
          end
          if (idx == IDX_LAST) begin
            state   <= GUARD;
            init    <= 1'b0;
            CS      <= 1'b0;
            Address <= '0;
          end else begin
            state   <= VRD;
            Address <= addr_next;
            idx     <= idx + 1'b1;
          end
        end
`endif

        // One cycle with the port released but the CPU still held in reset.
        GUARD: begin
          state   <= RUN;
          cpu_rst <= 1'b0;
          done    <= 1'b1;
        end

        RUN: state <= RUN;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
module tb_boot_loader;

  localparam int unsigned AW = 7;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Reference copy of the program image.
  logic [31:0] img [10] = '{
    32'h2001_0006, 32'h2002_0030, 32'h0001_4140, 32'h0001_4900, 32'h0109_4020,
    32'hAC01_0050, 32'hAC08_0054, 32'h8C03_0050, 32'hAC03_0058, 32'h0800_0009
  };

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- DUT A: defaults, auto start ----------------
  logic rst_a, init_a, cs_a, we_a, oe_a, cpu_rst_a, done_a, err_a;
  logic [AW-1:0] addr_a;
  logic [DW-1:0] bus_out_a, bus_in_a;
  logic [DW-1:0] mem_a [128];
  logic corrupt;

  boot_loader #(.N_WORDS(10), .BASE_ADDR(0), .AUTO_START(1)) u_a (
    .CLK(clk), .rst(rst_a), .start(1'b0), .init(init_a), .CS(cs_a), .WE(we_a),
    .Address(addr_a), .bus_out(bus_out_a), .bus_oe(oe_a), .bus_in(bus_in_a),
    .cpu_rst(cpu_rst_a), .done(done_a), .err(err_a)
  );

  always @(posedge clk) if (cs_a && we_a) mem_a[addr_a] = bus_out_a;
  assign bus_in_a = (corrupt && addr_a == 7'd3) ? ~mem_a[addr_a] : mem_a[addr_a];

  // ---------------- DUT B: start-triggered ----------------
  logic rst_b, start_b, init_b, cs_b, we_b, oe_b, cpu_rst_b, done_b, err_b;
  logic [AW-1:0] addr_b;
  logic [DW-1:0] bus_out_b;

  boot_loader #(.N_WORDS(10), .BASE_ADDR(0), .AUTO_START(0)) u_b (
    .CLK(clk), .rst(rst_b), .start(start_b), .init(init_b), .CS(cs_b), .WE(we_b),
    .Address(addr_b), .bus_out(bus_out_b), .bus_oe(oe_b), .bus_in('0),
    .cpu_rst(cpu_rst_b), .done(done_b), .err(err_b)
  );

  // ---------------- DUT C: wrapping base ----------------
  logic rst_c, init_c, cs_c, we_c, oe_c, cpu_rst_c, done_c, err_c;
  logic [AW-1:0] addr_c;
  logic [DW-1:0] bus_out_c, bus_in_c;
  logic [DW-1:0] mem_c [128];

  boot_loader #(.N_WORDS(4), .BASE_ADDR(125), .AUTO_START(1)) u_c (
    .CLK(clk), .rst(rst_c), .start(1'b0), .init(init_c), .CS(cs_c), .WE(we_c),
    .Address(addr_c), .bus_out(bus_out_c), .bus_oe(oe_c), .bus_in(bus_in_c),
    .cpu_rst(cpu_rst_c), .done(done_c), .err(err_c)
  );

  always @(posedge clk) if (cs_c && we_c) mem_c[addr_c] = bus_out_c;
  assign bus_in_c = mem_c[addr_c];

  // ---------------- scoreboards: {addr, data} per expected write ----------------
  logic [38:0] exp_a [$];
  logic [38:0] exp_c [$];
  logic [38:0] e_a, e_c;
  int wr_cnt_a = 0;
  int wr_cnt_c = 0;

  always @(negedge clk) begin
    if (cs_a && we_a) begin
      wr_cnt_a++;
      if (exp_a.size() == 0) check("a_unexpected_wr", 1, 0);
      else begin
        e_a = exp_a.pop_front();
        check("a_wr_addr", 64'(addr_a), 64'(e_a[38:32]));
        check("a_wr_data", 64'(bus_out_a), 64'(e_a[31:0]));
      end
    end
    if (cs_c && we_c) begin
      wr_cnt_c++;
      if (exp_c.size() == 0) check("c_unexpected_wr", 1, 0);
      else begin
        e_c = exp_c.pop_front();
        check("c_wr_addr", 64'(addr_c), 64'(e_c[38:32]));
        check("c_wr_data", 64'(bus_out_c), 64'(e_c[31:0]));
      end
    end
  end

  task automatic push_a();
    for (int i = 0; i < 10; i++) exp_a.push_back({7'(i), img[i]});
  endtask

  task automatic clear_mem_a();
    for (int i = 0; i < 128; i++) mem_a[i] = '0;
  endtask

  task automatic check_reset_a();
    check("a_rst_ctl", 64'({init_a, cs_a, we_a, oe_a, cpu_rst_a, done_a, err_a}), 64'(7'b0000100));
    check("a_rst_addr", 64'(addr_a), 64'(0));
    check("a_rst_data", 64'(bus_out_a), 64'(0));
  endtask

  task automatic wait_done_a(input int budget);
    for (int k = 0; k < budget && !done_a; k++) @(negedge clk);
    check("a_done_timeout", 64'(done_a), 64'(1));
  endtask

  task automatic check_mem_a();
    check("a_sb_empty", 64'(exp_a.size()), 64'(0));
    check("a_wr_count", 64'(wr_cnt_a), 64'(10));
    for (int i = 0; i < 10; i++) check("a_mem", 64'(mem_a[i]), 64'(img[i]));
  endtask

`ifdef VERIFY_READBACK_EN
  localparam int VFY_CYC = 20;
`else
  localparam int VFY_CYC = 0;
`endif

  int  seen;
  int  wr_b;
  logic found;

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1; start_b = 1'b0; corrupt = 1'b0;
    clear_mem_a();
    for (int i = 0; i < 128; i++) mem_c[i] = '0;
    #1;
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    @(negedge clk);
    check_reset_a();

    // Full load with exact cycle sequence.
    @(negedge clk);
    rst_a = 1'b1; wr_cnt_a = 0; push_a();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("a_load_ctl", 64'({init_a, cs_a, we_a, oe_a, cpu_rst_a, done_a}), 64'(6'b111110));
    end
    for (int k = 0; k < VFY_CYC; k++) begin
      @(negedge clk);
      check("a_verify_ctl", 64'({init_a, cs_a, we_a, oe_a, cpu_rst_a, done_a}), 64'(6'b110010));
    end
    @(negedge clk);
    check("a_guard", 64'({init_a, cs_a, we_a, oe_a, cpu_rst_a, done_a}), 64'(6'b000010));
    @(negedge clk);
    check("a_run", 64'({init_a, cs_a, we_a, oe_a, cpu_rst_a, done_a}), 64'(6'b000001));
    check_mem_a();
    check("a_err_clean", 64'(err_a), 64'(0));

    // Reset in the middle of the load, then a complete reload.
    @(negedge clk);
    rst_a = 1'b0;
    #1;
    exp_a.delete();
    clear_mem_a();
    @(negedge clk);
    rst_a = 1'b1; wr_cnt_a = 0; push_a();
    found = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      @(negedge clk);
      if (cs_a && we_a && addr_a == 7'd5) found = 1'b1;
    end
    check("a_reach_word5", 64'(found), 64'(1));
    #1 rst_a = 1'b0;
    #1 check_reset_a();
    exp_a.delete();
    @(negedge clk);
    clear_mem_a();
    rst_a = 1'b1; wr_cnt_a = 0; push_a();
    wait_done_a(100);
    check_mem_a();

`ifdef VERIFY_READBACK_EN
    // Corrupted readback of word 3 flags err but still releases the CPU.
    @(negedge clk);
    rst_a = 1'b0; corrupt = 1'b1;
    #1 exp_a.delete();
    @(negedge clk);
    rst_a = 1'b1; wr_cnt_a = 0; push_a();
    wait_done_a(100);
    check("a_err_corrupt", 64'(err_a), 64'(1));
    check("a_cpu_released", 64'(cpu_rst_a), 64'(0));
    corrupt = 1'b0;
`endif

    // Start-triggered instance: idle without start, then one pulse.
    @(negedge clk);
    rst_b = 1'b1;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (cs_b || we_b || init_b) seen++;
    end
    check("b_idle_no_access", 64'(seen), 64'(0));
    check("b_idle_cpu_rst", 64'(cpu_rst_b), 64'(1));
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    check("b_first_wr_ctl", 64'({cs_b, we_b, addr_b}), 64'({2'b11, 7'd0}));
    check("b_first_wr_data", 64'(bus_out_b), 64'(img[0]));
    wr_b = 1;
    for (int k = 0; k < 60 && !done_b; k++) begin
      @(negedge clk);
      if (cs_b && we_b) wr_b++;
    end
    check("b_done", 64'(done_b), 64'(1));
    check("b_wr_count", 64'(wr_b), 64'(10));
    start_b = 1'b1;
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (cs_b || init_b || !done_b || cpu_rst_b) seen++;
    end
    start_b = 1'b0;
    check("b_start_ignored_in_run", 64'(seen), 64'(0));

    // Wrapping base address instance.
    @(negedge clk);
    rst_c = 1'b1; wr_cnt_c = 0;
    for (int i = 0; i < 4; i++) exp_c.push_back({7'(125 + i), img[i]});
    for (int k = 0; k < 60 && !done_c; k++) @(negedge clk);
    check("c_done", 64'(done_c), 64'(1));
    check("c_sb_empty", 64'(exp_c.size()), 64'(0));
    check("c_wr_count", 64'(wr_cnt_c), 64'(4));
    check("c_mem_125", 64'(mem_c[125]), 64'(img[0]));
    check("c_mem_127", 64'(mem_c[127]), 64'(img[2]));
    check("c_mem_wrap0", 64'(mem_c[0]), 64'(img[3]));
    check("c_err", 64'(err_c), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
